// File: rtl/decoder_3to8_stream.sv
// rtl/decoder_3to8_stream.sv - streaming 3-to-8 one-hot decoder with input FIFO and delivered-word counter
module decoder_3to8_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     flush,
    output logic [7:0]               dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t  state, state_nxt;
    logic [2:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, empty, push, pop, deliver;

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign din_ready  = !full && !rst && !flush;
    assign push       = din_valid && din_ready;
    assign dout_valid = (state == OUT_FULL);

    always_ff @(posedge clk) begin
        if (rst) state <= OUT_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        deliver   = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (dout_ready) begin
                    deliver = 1'b1;
                    if (!empty) pop = 1'b1;
                    else        state_nxt = OUT_EMPTY;
                end
            end
            default: state_nxt = OUT_EMPTY;
        endcase
        // Flush drops both handshakes offered in its cycle.
        if (flush) begin
            pop       = 1'b0;
            deliver   = 1'b0;
            state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            dout  <= 8'h00;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            dout  <= 8'h00;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + PTR_ONE;
                2'b01:   level <= level - PTR_ONE;
                default: level <= level;
            endcase
            if (pop)          dout <= 8'h01 << mem[rptr[AW-1:0]];
            else if (deliver) dout <= 8'h00;
            if (deliver) count <= count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_decoder_3to8_stream.sv
// tb/tb_decoder_3to8_stream.sv - self-checking bench for decoder_3to8_stream
module tb_decoder_3to8_stream;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       flush;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       count;

    int total = 0;
    int bad   = 0;

    decoder_3to8_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .flush(flush), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .count(count)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] c);
        logic [7:0] one;
        one = 8'h01;
        return one << c;
    endfunction

    // Scoreboard: every word held by the DUT (FIFO plus output register), head first.
    logic [7:0]       sb_q[$];
    logic             m_ov  = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    always @(negedge clk) begin
        int  fifo_cnt;
        logic exp_ready;
        fifo_cnt  = sb_q.size() - (m_ov ? 1 : 0);
        exp_ready = !rst && !flush && (fifo_cnt < DEPTH);
        check("sb_din_ready", din_ready, exp_ready);
        check("sb_dout_valid", dout_valid, m_ov);
        check("sb_dout", dout, m_ov ? sb_q[0] : 8'h00);
        check("sb_level", level, fifo_cnt);
        check("sb_count", count, m_cnt);
        if (rst) begin
            sb_q.delete();
            m_ov  = 1'b0;
            m_cnt = '0;
        end else if (flush) begin
            sb_q.delete();
            m_ov = 1'b0;
        end else begin
            if (m_ov && dout_ready) begin
                void'(sb_q.pop_front());
                m_cnt = m_cnt + 1'b1;
                m_ov  = (fifo_cnt > 0);
            end else if (!m_ov) begin
                m_ov = (fifo_cnt > 0);
            end
            if (din_valid && exp_ready) sb_q.push_back(onehot(din));
        end
    end

    typedef struct {
        logic [2:0] code;
        logic [7:0] word;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 40 && (dout_valid || level != 0); i++) tick();
        check("drain_idle", {dout_valid, 3'(level)}, 4'h0);
    endtask

    task automatic push_codes(input int n, input logic [2:0] base);
        for (int i = 0; i < n; i++) begin
            din       = base + 3'(i);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 8'h01}; vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04}; vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10}; vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40}; vecs[7] = '{3'd7, 8'h80};

        rst = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        check("rst_din_ready", din_ready, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_level", level, 0);
        check("rst_count", count, 0);
        rst = 1'b0;
        #1 check("post_rst_din_ready", din_ready, 1);

        // Sweep 0..7 at full rate
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = vecs[i].code; din_valid = 1'b1;
            tick();
            if (i == 0) check("latency_not_yet", dout_valid, 0);
            else        check($sformatf("sweep_%0d", i-1), dout, vecs[i-1].word);
        end
        din_valid = 1'b0;
        tick();
        check("sweep_7", dout, vecs[7].word);
        tick();
        check("sweep_idle", dout_valid, 0);
        check("sweep_count", count, 8);

        // Backpressure until full
        dout_ready = 1'b0;
        begin
            logic [2:0] bp[6];
            bp[0] = 3'd3; bp[1] = 3'd5; bp[2] = 3'd1; bp[3] = 3'd7; bp[4] = 3'd2; bp[5] = 3'd6;
            for (int i = 0; i < 6; i++) begin
                din = bp[i]; din_valid = 1'b1;
                #1 check($sformatf("bp_ready_%0d", i), din_ready, (i < 5) ? 1 : 0);
                tick();
            end
        end
        check("bp_level_full", level, 4);
        check("bp_head", dout, 8'h08);
        check("bp_full_ready", din_ready, 0);

        // Pop at full while din_valid held: no push in the pop cycle
        dout_ready = 1'b1;
        tick();
        check("pop_at_full_level", level, 3);
        check("pop_at_full_dout", dout, 8'h20);
        tick();
        check("push_resumed_level", level, 3);
        check("push_resumed_dout", dout, 8'h02);
        drain();
        check("bp_count", count, 8 + 6);

        // Flush with count=5 and 3 words buffered
        rst = 1'b1; tick(); rst = 1'b0;
        dout_ready = 1'b1;
        push_codes(5, 3'd2);
        drain();
        check("pre_flush_count", count, 5);
        dout_ready = 1'b0;
        push_codes(4, 3'd4);
        check("pre_flush_level", level, 3);
        dout_ready = 1'b1; flush = 1'b1; din = 3'd1; din_valid = 1'b1;
        #1 check("flush_din_ready", din_ready, 0);
        tick();
        flush = 1'b0; din_valid = 1'b0;
        check("flush_dout_valid", dout_valid, 0);
        check("flush_dout", dout, 8'h00);
        check("flush_level", level, 0);
        check("flush_count", count, 5);

        // Reset while full and presenting
        dout_ready = 1'b0;
        push_codes(5, 3'd0);
        check("prerst_level", level, 4);
        check("prerst_valid", dout_valid, 1);
        rst = 1'b1; flush = 1'b1;
        tick();
        check("midrst_valid", dout_valid, 0);
        check("midrst_dout", dout, 8'h00);
        check("midrst_level", level, 0);
        check("midrst_count", count, 0);
        check("midrst_din_ready", din_ready, 0);
        rst = 1'b0; flush = 1'b0;
        dout_ready = 1'b1;
        din = 3'd6; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        check("after_rst_dout", dout, 8'h40);
        tick();
        check("after_rst_count", count, 1);

        // Counter wrap
        begin
            bit hit = 1'b0;
            din_valid = 1'b1; dout_ready = 1'b1;
            for (int i = 0; i < 600 && !hit; i++) begin
                din = 3'($urandom_range(0, 7));
                tick();
                if (count == 8'd255) hit = 1'b1;
            end
            check("wrap_reached_255", hit, 1);
            check("wrap_valid", dout_valid, 1);
            tick();
            check("wrap_to_0", count, 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        total++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_3to8_stream.md
# decoder_3to8_stream

Streaming 3-to-8 one-hot decoder: the inverse of the team's 8-to-3 encoder. Accepts 3-bit codes over a valid/ready interface, buffers them in a small FIFO, and presents each as a registered 8-bit one-hot word over a second valid/ready interface. It also keeps a count of delivered words. It sits downstream of encoder-produced code streams to regenerate the one-hot select lines.

## Interface
- DEPTH, 4: input FIFO depth in entries; power of two, 2..16.
- CNT_W, 8: width of the delivered-word counter.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  3  code to decode.
- din_valid  input  1  din holds a code.
- din_ready  output  1  block can accept a code this cycle.
- flush  input  1  synchronous clear of buffered data; count is kept.
- dout  output  8  one-hot decoded word; 8'h00 when dout_valid is 0.
- dout_valid  output  1  dout holds a decoded word.
- dout_ready  input  1  consumer takes dout this cycle.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

## Operation
- Input handshake: a code is accepted when din_valid && din_ready at a rising edge.
  - din_ready = !full && !rst && !flush.
  - When full, nothing is accepted, even if a pop happens in the same cycle.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH)+1 bits.
  - The MSB distinguishes full from empty. Pointers wrap DEPTH-1 -> 0.
  - A simultaneous push and pop leaves level unchanged.
- Output stage has two states.
  - OUT_EMPTY (dout_valid=0): if the FIFO is non-empty, load the head at the next edge and go to OUT_FULL.
  - OUT_FULL (dout_valid=1): dout is held stable until dout_valid && dout_ready.
    - On that edge, count increments.
    - If the FIFO is non-empty, load the next head and stay in OUT_FULL; this gives back-to-back words at 1 per cycle.
    - Otherwise go to OUT_EMPTY.
- Decode: dout = 8'b1 << code, so 3'd0 -> 8'h01 and 3'd7 -> 8'h80. Exactly one bit is set whenever dout_valid=1.
- count wraps from 2^CNT_W-1 to 0.
- flush, at the edge where it is high:
  - Pointers reset, level=0, output goes to OUT_EMPTY, dout=0.
  - A handshake offered in that cycle on either side is ignored; count does not increment.
- Reset, at the edge where rst is high:
  - FIFO empty, level=0, dout=8'h00, dout_valid=0, count=0, output state OUT_EMPTY.
  - din_ready=0 while rst is high and 1 from the first cycle after.
  - Reset mid-stream discards all buffered and presented words.
  - rst has priority over flush.

## Timing
- All outputs except din_ready are registered. din_ready is combinational from the full flag, rst and flush; it does not depend on din_valid or dout_ready.
- Latency with an empty pipeline: a code accepted at edge k is written to the FIFO. It is loaded into the output register at edge k+1, so dout_valid is high in the cycle after edge k+1 (2 edges).
- Sustained throughput is 1 word per cycle when din_valid and dout_ready are held high.
- Total buffering is DEPTH + 1 words: FIFO plus output register.
- level updates at the same edge as the push or pop that changes it.
- count updates at the edge of the output handshake and is visible in the following cycle.

## Test plan
- Reset then sweep: after rst, push codes 0..7 with dout_ready=1.
  - Required: dout shows 01,02,04,08,10,20,40,80 on consecutive cycles, first word 2 edges after its acceptance.
  - Final count=8.
- Backpressure/full: hold dout_ready=0 and push codes 3,5,1,7,2.
  - Required: 3 is presented as 8'h08; level reaches 4 with DEPTH=4, then din_ready=0 and the 6th code is not accepted.
  - Release dout_ready: words 08,20,02,80,04 appear in order with no loss or duplication.
- Simultaneous push/pop at full: with FIFO full and dout_ready=1, hold din_valid=1.
  - Required: no push in the pop cycle; level goes 4 -> 3; push resumes the next cycle.
- Flush mid-stream: with 3 words buffered and count=5, assert flush for one cycle with dout_ready=1.
  - Required: dout_valid=0, dout=00, level=0, count stays 5.
- Reset mid-operation: with the FIFO full and dout_valid=1, assert rst.
  - Required: all outputs return to reset values the next cycle.
  - Subsequent code 6 yields dout=8'h40, count=1.
- Counter wrap with CNT_W=8: deliver 256 words.
  - Required: count goes 255 -> 0.
